if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter PC_W, default 32, width of the program-counter field carried with each instruction.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  fetch side presents an instruction.
REQ-005 in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 in_instr  input  32  fetched MIPS instruction word.
REQ-007 in_pc  input  PC_W  address of in_instr.
REQ-008 flush  input  1  discard all held and incoming instructions (branch/jump redirect).
REQ-009 out_valid  output  1  decode side has a valid instruction.
REQ-010 out_ready  input  1  decode side consumes the head instruction this cycle.
REQ-011 out_pc  output  PC_W  PC of head instruction.
REQ-012 out_opcode  output  6  head instr[31:26].
REQ-013 out_rs / out_rt / out_rd  output  5 each  head instr[25:21] / [20:16] / [15:11].
REQ-014 out_shamt  output  5  head instr[10:6]; out_funct  output  6  head instr[5:0].
REQ-015 out_imm16  output  16  head instr[15:0]; feeds the 16-to-32 sign extender unmodified.
REQ-016 out_jaddr  output  26  head instr[25:0].
REQ-017 stall_cnt  output  16  decode-stall cycle count; present only when IF_ID_STALL_CNT_EN is defined.

Function
REQ-018 The stage SHALL be a 2-entry in-order buffer with states EMPTY, ONE, FULL, held in a registered state variable.
REQ-019 Accept = in_valid && in_ready; emit = out_valid && out_ready; both evaluated on the same edge.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, decoded from registered state only (no combinational path from out_ready).
REQ-021 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-022 Transitions: EMPTY+accept->ONE; ONE+accept, no emit->FULL; ONE+emit, no accept->EMPTY; ONE+accept+emit->ONE with new entry as head; FULL+emit->ONE with second entry promoted to head; all other cases hold state.
REQ-023 Latency: an instruction accepted at edge N SHALL appear on outputs with out_valid=1 from edge N until emitted; minimum accept-to-emit is 1 cycle.
REQ-024 Order SHALL be strictly preserved; no instruction is duplicated or dropped except by flush.
REQ-025 All out_* field ports SHALL be pure bit-slices of the head entry's stored word; no sign or zero extension inside this block.
REQ-026 In EMPTY all out_* data ports SHALL drive zero.
REQ-027 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 flush=1 SHALL force next state EMPTY, discarding both entries and any same-cycle accepted instruction; flush overrides accept and emit.
REQ-029 An instruction word 32'h00000000 (nop) SHALL be handled as ordinary data.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force EMPTY, clear both entries to zero, and clear stall_cnt, regardless of flush, in_valid or out_ready.
REQ-031 Post-reset outputs: out_valid=0, in_ready=1, all out_* data zero.
REQ-032 Reset asserted mid-transfer SHALL discard held instructions; no emit is reported in the reset cycle.

Configuration
REQ-033 Macro IF_ID_STALL_CNT_EN defined: stall_cnt port exists and increments by 1 on each edge with out_valid=1 and out_ready=0, saturating at 16'hFFFF, cleared only by reset.
REQ-034 Macro IF_ID_STALL_CNT_EN undefined: stall_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Reset, then in_instr=32'h2008FFFC, in_pc=32'h00000004, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, out_opcode=6'h08, out_rt=5'd8, out_imm16=16'hFFFC, out_pc=32'h00000004; following cycle out_valid=0.
REQ-036 out_ready=0, push 3 words A,B,C on consecutive cycles -> A,B accepted, in_ready=0 after B, C held upstream; then out_ready=1 -> emits A,B,C in order.
REQ-037 ONE state with simultaneous accept and emit for 8 cycles -> state stays ONE, in_ready=1 throughout, 8 words emitted in order, 1-cycle latency each.
REQ-038 FULL with flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, out_* zero; no held or incoming word ever emitted.
REQ-039 rst_n=0 while FULL and out_ready=1 -> next cycle EMPTY, out_valid=0, stall_cnt=0.
REQ-040 With IF_ID_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and stays; without macro, bench elaborates with no stall_cnt port.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Handshake and decoded-field bundle between fetch, the IF/ID buffer and decode.
// The stage itself connects through the slave modport; the driving environment uses master.
interface if_id_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      out_opcode;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_rd;
    logic [4:0]      out_shamt;
    logic [5:0]      out_funct;
    logic [15:0]     out_imm16;
    logic [25:0]     out_jaddr;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm16, out_jaddr
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm16, out_jaddr
    );
endinterface

// File: rtl/if_id_stage.sv
// Two-entry in-order IF/ID buffer that slices the head MIPS word into decode fields.
// Define IF_ID_STALL_CNT_EN to add the saturating decode-stall counter port stall_cnt.
module if_id_stage #(
    parameter int PC_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    if_id_stage_if.slave bus
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [31:0]     head_instr_q, head_instr_d;
    logic [PC_W-1:0] head_pc_q, head_pc_d;
    logic [31:0]     tail_instr_q, tail_instr_d;
    logic [PC_W-1:0] tail_pc_q, tail_pc_d;
    logic            accept;
    logic            emit;
    logic [31:0]     head_word;

    assign accept = bus.in_valid && bus.in_ready;
    assign emit   = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !emit)      state_d = FULL;
                    else if (emit && !accept) state_d = EMPTY;
                end
                FULL:    if (emit) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Entry moves: the tail only fills from ONE and only drains into the head.
    always_comb begin
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        if (bus.flush) begin
            head_instr_d = '0;
            head_pc_d    = '0;
            tail_instr_d = '0;
            tail_pc_d    = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_instr_d = bus.in_instr;
                        head_pc_d    = bus.in_pc;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        head_instr_d = bus.in_instr;
                        head_pc_d    = bus.in_pc;
                    end else if (accept) begin
                        tail_instr_d = bus.in_instr;
                        tail_pc_d    = bus.in_pc;
                    end else if (emit) begin
                        head_instr_d = '0;
                        head_pc_d    = '0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                        tail_instr_d = '0;
                        tail_pc_d    = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and data outputs come from registered state only.
    always_comb begin
        bus.in_ready   = (state_q == EMPTY) || (state_q == ONE);
        bus.out_valid  = (state_q == ONE) || (state_q == FULL);
        head_word      = bus.out_valid ? head_instr_q : 32'h0;
        bus.out_pc     = bus.out_valid ? head_pc_q : '0;
        bus.out_opcode = head_word[31:26];
        bus.out_rs     = head_word[25:21];
        bus.out_rt     = head_word[20:16];
        bus.out_rd     = head_word[15:11];
        bus.out_shamt  = head_word[10:6];
        bus.out_funct  = head_word[5:0];
        bus.out_imm16  = head_word[15:0];
        bus.out_jaddr  = head_word[25:0];
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (bus.out_valid && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for the IF/ID buffer: reset, single transfer, backpressure,
// back-to-back streaming, flush, mid-transfer reset, nop and (optionally) stall counter.
module tb_if_id_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    if_id_stage_if #(.PC_W(32)) bus();

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_cnt;
    if_id_stage #(.PC_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt));
`else
    if_id_stage #(.PC_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] out_word();
        return {bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_funct};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hDEADBEEF;
        bus.in_pc     = 32'h12345678;
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake got out_valid=%0b in_ready=%0b exp 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (out_word() !== 32'h0 || bus.out_pc !== 32'h0 || bus.out_imm16 !== 16'h0 || bus.out_jaddr !== 26'h0) begin
            failures++;
            $display("FAIL reset_data got word=%h pc=%h exp 0", out_word(), bus.out_pc);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single();
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h2008FFFC;
        bus.in_pc     = 32'h00000004;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_opcode !== 6'h08 || bus.out_rt !== 5'd8) begin
            failures++;
            $display("FAIL single_fields got v=%0b op=%h rt=%0d exp 1/08/8", bus.out_valid, bus.out_opcode, bus.out_rt);
        end
        checks++;
        if (bus.out_imm16 !== 16'hFFFC || bus.out_pc !== 32'h4 || bus.out_rs !== 5'd0) begin
            failures++;
            $display("FAIL single_imm got imm=%h pc=%h rs=%0d exp FFFC/4/0", bus.out_imm16, bus.out_pc, bus.out_rs);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
            failures++;
            $display("FAIL single_drain got v=%0b pc=%h exp 0/0", bus.out_valid, bus.out_pc);
        end
        $display("test_single done");
    endtask

    task automatic test_backpressure();
        logic [31:0] wa, wb, wc;
        wa = 32'h8C220010;
        wb = 32'h00851020;
        wc = 32'h08000123;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = wa;
        bus.in_pc     = 32'h100;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || out_word() !== wa) begin
            failures++;
            $display("FAIL bp_one got rdy=%0b word=%h exp 1/%h", bus.in_ready, out_word(), wa);
        end
        bus.in_instr = wb;
        bus.in_pc    = 32'h104;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || out_word() !== wa || bus.out_pc !== 32'h100) begin
            failures++;
            $display("FAIL bp_full got rdy=%0b word=%h pc=%h exp 0/%h/100", bus.in_ready, out_word(), bus.out_pc, wa);
        end
        bus.in_instr = wc;
        bus.in_pc    = 32'h108;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || out_word() !== wa || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold got rdy=%0b word=%h exp 0/%h", bus.in_ready, out_word(), wa);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (out_word() !== wb || bus.out_pc !== 32'h104 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_emit_b got word=%h pc=%h rdy=%0b exp %h/104/1", out_word(), bus.out_pc, bus.in_ready, wb);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (out_word() !== wc || bus.out_pc !== 32'h108 || bus.out_jaddr !== wc[25:0]) begin
            failures++;
            $display("FAIL bp_emit_c got word=%h pc=%h exp %h/108", out_word(), bus.out_pc, wc);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got v=%0b exp 0", bus.out_valid);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h10000000;
        bus.in_pc     = 32'h0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            w = 32'h10000000 + 32'(k * 32'h01010101);
            bus.in_instr = w;
            bus.in_pc    = 32'(4 * k);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || out_word() !== w ||
                bus.out_pc !== 32'(4 * k) || bus.out_jaddr !== w[25:0] || bus.out_imm16 !== w[15:0]) begin
                failures++;
                $display("FAIL b2b_%0d got v=%0b rdy=%0b word=%h pc=%h exp 1/1/%h/%h",
                         k, bus.out_valid, bus.in_ready, out_word(), bus.out_pc, w, 32'(4 * k));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got v=%0b exp 0", bus.out_valid);
        end
        $display("test_back_to_back done");
    endtask

    task automatic fill_full();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hAAAA5555;
        bus.in_pc     = 32'h200;
        tick();
        bus.in_instr  = 32'h5555AAAA;
        bus.in_pc     = 32'h204;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_flush();
        fill_full();
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFFFFFFF;
        bus.in_pc     = 32'h300;
        tick();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || out_word() !== 32'h0 || bus.out_pc !== 32'h0) begin
            failures++;
            $display("FAIL flush_empty got v=%0b rdy=%0b word=%h pc=%h exp 0/1/0/0",
                     bus.out_valid, bus.in_ready, out_word(), bus.out_pc);
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_emit got v=%0b exp 0", bus.out_valid);
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        fill_full();
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || out_word() !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid got v=%0b rdy=%0b word=%h exp 0/1/0", bus.out_valid, bus.in_ready, out_word());
        end
`ifdef IF_ID_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'h0) begin
            failures++;
            $display("FAIL rst_mid_cnt got %h exp 0", stall_cnt);
        end
`endif
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after got v=%0b exp 0", bus.out_valid);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_nop();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 32'h40;
        tick();
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || out_word() !== 32'h0) begin
            failures++;
            $display("FAIL nop_head got v=%0b pc=%h word=%h exp 1/40/0", bus.out_valid, bus.out_pc, out_word());
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL nop_drain got v=%0b exp 0", bus.out_valid);
        end
        $display("test_nop done");
    endtask

`ifdef IF_ID_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h24010001;
        bus.in_pc    = 32'h80;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (stall_cnt !== 16'd5) begin
            failures++;
            $display("FAIL stall_cnt_5 got %0d exp 5", stall_cnt);
        end
        repeat (70000) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stall_cnt_sat got %h exp FFFF", stall_cnt);
        end
        repeat (10) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF || out_word() !== 32'h24010001) begin
            failures++;
            $display("FAIL stall_cnt_hold got %h word=%h exp FFFF/24010001", stall_cnt, out_word());
        end
        $display("test_stall_cnt done");
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_nop();
`ifdef IF_ID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
